// File: rtl/barrel_rotl_pipe_pkg.sv
// Shared constants for the pipelined left rotator/shifter.
// Mode encodings and per-stage shift distances live here so stage wiring and the bench agree.
package barrel_rotl_pipe_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int SHW_DEF   = 3;

    localparam logic MODE_ROTL = 1'b0;
    localparam logic MODE_SHL  = 1'b1;

    localparam int DIST_S2 = 4;
    localparam int DIST_S1 = 2;
    localparam int DIST_S0 = 1;
endpackage

// File: rtl/barrel_rotl_pipe_stage.sv
// One registered log-stage: conditionally moves the operand left by DIST on capture
// and forwards the amount/mode so later stages can apply their own bit.
module rotl_stage
    import barrel_rotl_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SHW-1:0]   up_amt,
    input  logic             up_mode,
    input  logic             dn_ready,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   amt,
    output logic             mode
);
    localparam int BIT = $clog2(DIST);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] moved;

    assign shifted = up_data << DIST;

    always_comb begin
        moved = up_data;
        if (up_amt[BIT]) begin
            // Rotate wraps the bits pushed out of the top back into the vacated low bits.
            moved = (up_mode == MODE_SHL) ? shifted : (shifted | (up_data >> (WIDTH - DIST)));
        end
    end

    // The slot may refill when it is empty or its occupant leaves this cycle.
    assign up_ready = ~vld | dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
            amt  <= '0;
            mode <= 1'b0;
        end else if (up_ready) begin
            vld <= up_valid;
            if (up_valid) begin
                data <= moved;
                amt  <= up_amt;
                mode <= up_mode;
            end
        end
    end
endmodule

// File: rtl/barrel_rotl_pipe.sv
// Three-stage (4, 2, 1) pipelined left rotator / logical left shifter with valid/ready on
// both sides; the ready chain is combinational so empty slots pass readiness upstream.
module barrel_rotl_pipe
    import barrel_rotl_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             v2, v1;
    logic [WIDTH-1:0] d2, d1;
    logic [SHW-1:0]   a2, a1;
    logic             m2, m1;
    logic             s1_ready, s0_ready;

    // The final stage's amount/mode have no consumer once the last bit is applied.
    logic [SHW-1:0]   unused_amt0;
    logic             unused_mode0;

    rotl_stage #(.WIDTH(WIDTH), .SHW(SHW), .DIST(DIST_S2)) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (in_data),
        .up_amt   (in_amt),
        .up_mode  (in_mode),
        .dn_ready (s1_ready),
        .vld      (v2),
        .data     (d2),
        .amt      (a2),
        .mode     (m2)
    );

    rotl_stage #(.WIDTH(WIDTH), .SHW(SHW), .DIST(DIST_S1)) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (v2),
        .up_ready (s1_ready),
        .up_data  (d2),
        .up_amt   (a2),
        .up_mode  (m2),
        .dn_ready (s0_ready),
        .vld      (v1),
        .data     (d1),
        .amt      (a1),
        .mode     (m1)
    );

    rotl_stage #(.WIDTH(WIDTH), .SHW(SHW), .DIST(DIST_S0)) u_s0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (v1),
        .up_ready (s0_ready),
        .up_data  (d1),
        .up_amt   (a1),
        .up_mode  (m1),
        .dn_ready (out_ready),
        .vld      (out_valid),
        .data     (out_data),
        .amt      (unused_amt0),
        .mode     (unused_mode0)
    );
endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Scoreboard bench for barrel_rotl_pipe: stimulus pushes expected results, a forked monitor
// pops and compares on every output transfer, with latency checked where no stall occurs.
module tb_barrel_rotl_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_amt = '0;
    logic       in_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;

    barrel_rotl_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] exp;
        int         cyc;
        bit         lat;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  fails = 0;
    int  stalls = 0;
    bit  lat_chk = 1'b0;
    bit  rnd_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: rotate = multiply by 2^amt with the overflow folded back in; shift = truncate.
    function automatic logic [7:0] model(input int d, input int a, input bit m);
        int r;
        r = (d * (1 << a)) % 256;
        if (!m) r = r + (d >> (8 - a));
        return r[7:0];
    endfunction

    // Called at posedge+1; returns at posedge+1 after the item is accepted.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic m, input logic [7:0] exp);
        int w = 0;
        sb_t e;
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        else begin
            e.exp = exp; e.cyc = cyc; e.lat = lat_chk;
            sb.push_back(e);
        end
        stalls += w;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] sweep [8];
        logic [7:0] held;
        sb_t e;
        int k;
        sweep = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2};

        fork
            forever begin
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (sb.size() == 0) chk("unexpected_output", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.exp);
                        if (e.lat) chk("latency", cyc - e.cyc, 3);
                    end
                end
            end
            forever begin
                @(posedge clk); #1;
                if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            end
        join_none

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Rotate 1 and back-to-back sweep, both with latency checks
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(8'b1111_1110, 3'd1, 1'b0, 8'b1111_1101);
        idle(4);
        stalls = 0;
        for (int i = 0; i < 8; i++) send(8'hA5, 3'(i), 1'b0, sweep[i]);
        chk("sweep_stalls", stalls, 0);
        idle(4);

        // Logical shift boundaries
        send(8'h81, 3'd1, 1'b1, 8'h02);
        send(8'h81, 3'd7, 1'b1, 8'h80);
        send(8'hFF, 3'd4, 1'b1, 8'hF0);
        send(8'h3C, 3'd0, 1'b1, 8'h3C);
        send(8'h3C, 3'd0, 1'b0, 8'h3C);
        send(8'h81, 3'd7, 1'b0, 8'hC0);
        idle(4);
        lat_chk = 1'b0;

        // Backpressure: offer 5 items with the sink stalled
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h11 * (k + 1)); in_amt = 3'(k + 1); in_mode = 1'b0;
            @(negedge clk);
            if (in_ready) begin
                e.exp = model(8'h11 * (k + 1), k + 1, 1'b0); e.cyc = cyc; e.lat = 1'b0;
                sb.push_back(e);
                k++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", k, 3);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        held = out_data;
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        stalls = 0;
        for (int i = k; i < 11; i++) send(8'(8'h11 * (i + 1)), 3'(i + 1), 1'b0, model(8'h11 * (i + 1), (i + 1) % 8, 1'b0));
        chk("bp_full_rate_stalls", stalls, 0);
        drain();

        // Inverse of right rotate, exhaustive, with random backpressure and gaps
        rnd_rdy = 1'b1;
        for (int x = 0; x < 256; x++) begin
            for (int n = 0; n < 8; n++) begin
                send(8'(((x >> n) | (x << (8 - n))) & 255), 3'(n), 1'b0, 8'(x));
                if ($urandom_range(0, 7) == 0) idle(1);
            end
        end
        // Random mixed modes against the model
        for (int i = 0; i < 200; i++) begin
            int d = $urandom_range(0, 255);
            int a = $urandom_range(0, 7);
            bit m = 1'($urandom_range(0, 1));
            send(8'(d), 3'(a), m, model(d, a, m));
        end
        rnd_rdy = 1'b0;
        drain();
        idle(2);

        // Reset mid-flight with three items held in the pipe
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(8'h5A + i), 3'(i), 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        #1 chk("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        lat_chk = 1'b1;
        send(8'h0F, 3'd3, 1'b0, 8'h78);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
